// File: rtl/gpu_job_ctrl_if.sv
// Host / GPU / RAM bundle for the filter-GPU job controller.
// slave = controller side, master = surrounding host, GPU core and RAM.
interface gpu_job_ctrl_if #(
    parameter int unsigned ADDR_W = 10
);
    logic                  host_req;
    logic                  host_we;
    logic [ADDR_W-1:0]     host_addr;
    logic [2:0][17:0]      host_wdata;
    logic                  host_gnt;
    logic [2:0][17:0]      host_rdata;
    logic                  host_rvalid;

    logic                  gpu_hold;
    logic [31:0]           gpu_pc;
    logic                  gpu_we;
    logic [ADDR_W-1:0]     gpu_a1;
    logic [ADDR_W-1:0]     gpu_a2;
    logic [ADDR_W-1:0]     gpu_a3;
    logic [2:0][17:0]      gpu_wdata;
    logic [2:0][17:0]      gpu_rdata;

    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_a1;
    logic [ADDR_W-1:0]     mem_a2;
    logic [ADDR_W-1:0]     mem_a3;
    logic [2:0][17:0]      mem_wdata;
    logic [2:0][17:0]      mem_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output gpu_hold, gpu_rdata,
        input  gpu_pc, gpu_we, gpu_a1, gpu_a2, gpu_a3, gpu_wdata,
        output mem_we, mem_a1, mem_a2, mem_a3, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  gpu_hold, gpu_rdata,
        output gpu_pc, gpu_we, gpu_a1, gpu_a2, gpu_a3, gpu_wdata,
        input  mem_we, mem_a1, mem_a2, mem_a3, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/gpu_job_ctrl.sv
// Job sequencer and 3-lane data-RAM arbiter between a host loader and the filter GPU core.
// Optional watchdog enabled by defining GPU_TIMEOUT_EN.
module gpu_job_ctrl #(
    parameter int unsigned ADDR_W      = 10,
    parameter logic [31:0] HALT_PC     = 32'h0000_00FC,
    parameter int unsigned DRAIN_CYC   = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'h00FF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    gpu_job_ctrl_if.slave        bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [31:0]          cycle_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  drain_q, drain_d;
    logic [31:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
    logic        rvalid_q;

    logic        host_owns;
    logic        host_gnt;
    logic [31:0] cnt_inc;
    logic [ADDR_W-1:0] host_lane_addr [3];

    assign host_owns = (state_q == S_IDLE) || (state_q == S_DONE);
    assign host_gnt  = bus.host_req & host_owns;
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    // Host accesses a 3-word row: lane n sits at base+n, wrapping around the RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign host_lane_addr[gi] = bus.host_addr + ADDR_W'(gi);
        end
    endgenerate

`ifndef GPU_TIMEOUT_EN
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_RUN;
                    cnt_d     = 32'd0;
                    timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (bus.gpu_pc == HALT_PC) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_LOAD;
                end
`ifdef GPU_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_CYC - 32'd1) begin
                    state_d   = S_DRAIN;
                    drain_d   = DRAIN_LOAD;
                    timeout_d = 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (drain_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            drain_q   <= 4'd0;
            cnt_q     <= 32'd0;
            timeout_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            rvalid_q  <= host_gnt & ~bus.host_we;
        end
    end

    // Ownership follows the registered state only, never the same-cycle start.
    assign bus.mem_we    = host_owns ? (host_gnt & bus.host_we) : bus.gpu_we;
    assign bus.mem_a1    = host_owns ? host_lane_addr[0] : bus.gpu_a1;
    assign bus.mem_a2    = host_owns ? host_lane_addr[1] : bus.gpu_a2;
    assign bus.mem_a3    = host_owns ? host_lane_addr[2] : bus.gpu_a3;
    assign bus.mem_wdata = host_owns ? bus.host_wdata    : bus.gpu_wdata;

    assign bus.host_gnt    = host_gnt;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = bus.mem_rdata;
    assign bus.gpu_rdata   = bus.mem_rdata;
    assign bus.gpu_hold    = host_owns;

    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);
    assign timeout_o     = timeout_q;
    assign cycle_count_o = cnt_q;

endmodule
